// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch matrix fill engine:
// pointer codes, FSM encoding, nucleotide codes and default scoring.
package nw_pkg;

    localparam logic [1:0] PTR_DIAG = 2'b00;
    localparam logic [1:0] PTR_UP   = 2'b01;
    localparam logic [1:0] PTR_LEFT = 2'b10;

    localparam logic [1:0] NT_A = 2'b00;
    localparam logic [1:0] NT_C = 2'b01;
    localparam logic [1:0] NT_G = 2'b10;
    localparam logic [1:0] NT_T = 2'b11;

    localparam int NW_N        = 128;
    localparam int NW_W        = 16;
    localparam int NW_MATCH    = 1;
    localparam int NW_MISMATCH = -1;
    localparam int NW_GAP      = -2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_CALC = 2'b10,
        ST_DONE = 2'b11
    } nw_state_e;

endpackage

// File: rtl/nw_max3.sv
// Signed maximum of the three cell candidates plus the traceback pointer
// of the winner; ties resolve diag > up > left.
module nw_max3
    import nw_pkg::*;
#(
    parameter int W = NW_W
) (
    input  logic signed [W-1:0] diag_i,
    input  logic signed [W-1:0] up_i,
    input  logic signed [W-1:0] left_i,
    output logic signed [W-1:0] max_o,
    output logic        [1:0]   ptr_o
);

    // Priority select of the best candidate
    always_comb begin
        max_o = diag_i;
        ptr_o = PTR_DIAG;
        if ((diag_i >= up_i) && (diag_i >= left_i)) begin
            max_o = diag_i;
            ptr_o = PTR_DIAG;
        end else if (up_i >= left_i) begin
            max_o = up_i;
            ptr_o = PTR_UP;
        end else begin
            max_o = left_i;
            ptr_o = PTR_LEFT;
        end
    end

endmodule

// File: rtl/nw_matrix_filler.sv
// Fills the N x N Needleman-Wunsch score/pointer matrix one cell per two
// cycles: READ fetches the up neighbour, CALC scores and writes the cell.
module nw_matrix_filler
    import nw_pkg::*;
#(
    parameter int N        = NW_N,
    parameter int W        = NW_W,
    parameter int MATCH    = NW_MATCH,
    parameter int MISMATCH = NW_MISMATCH,
    parameter int GAP      = NW_GAP,
    localparam int IW      = $clog2(N) + 1,
    localparam int AW      = $clog2(N * N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IW-1:0]       i,
    input  logic [IW-1:0]       j,
    input  logic                end_filling,
    input  logic [1:0]          a_char,
    input  logic [1:0]          b_char,
    output logic                en_read,
    output logic                change_index,
    output logic [AW-1:0]       ram_addr,
    output logic                ram_we,
    output logic signed [W-1:0] ram_wdata,
    output logic [1:0]          ptr_wdata,
    input  logic signed [W-1:0] ram_rdata,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] final_score
);

    localparam logic signed [W-1:0] MATCH_W    = W'(MATCH);
    localparam logic signed [W-1:0] MISMATCH_W = W'(MISMATCH);
    localparam logic signed [W-1:0] GAP_W      = W'(GAP);

    nw_state_e state_q, state_d;

    logic signed [W-1:0] left_q, up_q, final_score_q;
    logic signed [W-1:0] up_s, left_s, diag_s, s_d_s, s_u_s, s_l_s, score_s;
    logic        [1:0]   ptr_s;
    logic [AW-1:0]       up_addr_s, cur_addr_s;

    // i=0 gives a wrapped up address; its read data is never used
    assign up_addr_s  = AW'((int'(i) - 1) * N + int'(j));
    assign cur_addr_s = AW'(int'(i) * N + int'(j));

    // Neighbour selection with matrix-border gap penalties
    always_comb begin
        up_s   = '0;
        left_s = '0;
        diag_s = '0;
        if (i != '0) begin
            up_s = ram_rdata;
        end else begin
            up_s = W'((int'(j) + 1) * GAP);
        end
        if (j != '0) begin
            left_s = left_q;
            diag_s = up_q;
        end else if (i != '0) begin
            left_s = W'((int'(i) + 1) * GAP);
            diag_s = W'(int'(i) * GAP);
        end else begin
            left_s = GAP_W;
            diag_s = '0;
        end
    end

    assign s_d_s = diag_s + ((a_char == b_char) ? MATCH_W : MISMATCH_W);
    assign s_u_s = up_s + GAP_W;
    assign s_l_s = left_s + GAP_W;

    nw_max3 #(.W(W)) u_max3 (
        .diag_i (s_d_s),
        .up_i   (s_u_s),
        .left_i (s_l_s),
        .max_o  (score_s),
        .ptr_o  (ptr_s)
    );

    // Next-state and per-state RAM/counter strobes
    always_comb begin
        state_d      = state_q;
        en_read      = 1'b0;
        change_index = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        ptr_wdata    = PTR_DIAG;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                en_read  = 1'b1;
                ram_addr = up_addr_s;
                state_d  = ST_CALC;
            end
            ST_CALC: begin
                en_read      = 1'b1;
                change_index = 1'b1;
                ram_we       = 1'b1;
                ram_addr     = cur_addr_s;
                ram_wdata    = score_s;
                ptr_wdata    = ptr_s;
                if (end_filling) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ST_READ) || (state_q == ST_CALC);
    assign done        = (state_q == ST_DONE);
    assign final_score = final_score_q;

    // State, row-carry registers and final score capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            left_q        <= '0;
            up_q          <= '0;
            final_score_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CALC) begin
                left_q <= score_s;
                up_q   <= up_s;
                if (end_filling) begin
                    final_score_q <= score_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_nw_matrix_filler.sv
// Randomized self-checking bench: two filler instances (N=4 defaults and
// N=2 with a harsh mismatch), each with a counter and score/pointer RAMs.
module tb_nw_matrix_filler;
    import nw_pkg::*;

    localparam int N1 = 4;
    localparam int N2 = 2;
    localparam int GAP = -2;
    localparam int MATCH = 1;

    logic clk = 1'b0;
    logic rst, start, sel;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Instance 1 (N=4)
    logic [2:0]         i1, j1;
    logic               ef1, en1, ch1, we1, busy1, done1;
    logic [1:0]         ac1, bc1, pw1;
    logic [3:0]         addr1;
    logic signed [15:0] wd1, rd1, fs1;
    logic [1:0]         sa1 [4];
    logic [1:0]         sb1 [4];
    logic signed [15:0] smem1 [16];
    logic [1:0]         pmem1 [16];

    // Instance 2 (N=2, MISMATCH=-4)
    logic [1:0]         i2, j2;
    logic               ef2, en2, ch2, we2, busy2, done2;
    logic [1:0]         ac2, bc2, pw2;
    logic [1:0]         addr2;
    logic signed [15:0] wd2, rd2, fs2;
    logic [1:0]         sa2 [2];
    logic [1:0]         sb2 [2];
    logic signed [15:0] smem2 [4];
    logic [1:0]         pmem2 [4];

    nw_matrix_filler #(.N(N1), .W(16), .MATCH(1), .MISMATCH(-1), .GAP(-2)) dut1 (
        .clk(clk), .rst(rst), .start(start & ~sel), .i(i1), .j(j1), .end_filling(ef1),
        .a_char(ac1), .b_char(bc1), .en_read(en1), .change_index(ch1), .ram_addr(addr1),
        .ram_we(we1), .ram_wdata(wd1), .ptr_wdata(pw1), .ram_rdata(rd1), .busy(busy1),
        .done(done1), .final_score(fs1)
    );

    nw_matrix_filler #(.N(N2), .W(16), .MATCH(1), .MISMATCH(-4), .GAP(-2)) dut2 (
        .clk(clk), .rst(rst), .start(start & sel), .i(i2), .j(j2), .end_filling(ef2),
        .a_char(ac2), .b_char(bc2), .en_read(en2), .change_index(ch2), .ram_addr(addr2),
        .ram_we(we2), .ram_wdata(wd2), .ptr_wdata(pw2), .ram_rdata(rd2), .busy(busy2),
        .done(done2), .final_score(fs2)
    );

    // Row-major insertion counters, wrapping to (0,0) after the last cell
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            i1 <= '0; j1 <= '0; i2 <= '0; j2 <= '0;
        end else begin
            if (ch1) begin
                if (j1 == 3'(N1 - 1)) begin
                    j1 <= '0;
                    i1 <= (i1 == 3'(N1 - 1)) ? 3'd0 : i1 + 3'd1;
                end else begin
                    j1 <= j1 + 3'd1;
                end
            end
            if (ch2) begin
                if (j2 == 2'(N2 - 1)) begin
                    j2 <= '0;
                    i2 <= (i2 == 2'(N2 - 1)) ? 2'd0 : i2 + 2'd1;
                end else begin
                    j2 <= j2 + 2'd1;
                end
            end
        end
    end

    assign ef1 = en1 && (i1 == 3'(N1 - 1)) && (j1 == 3'(N1 - 1));
    assign ef2 = en2 && (i2 == 2'(N2 - 1)) && (j2 == 2'(N2 - 1));
    assign ac1 = sa1[i1[1:0]];
    assign bc1 = sb1[j1[1:0]];
    assign ac2 = sa2[i2[0]];
    assign bc2 = sb2[j2[0]];

    // Behavioural RAMs with one-cycle read latency
    always @(posedge clk) begin
        rd1 <= smem1[addr1];
        rd2 <= smem2[addr2];
        if (we1) begin
            smem1[addr1] <= wd1;
            pmem1[addr1] <= pw1;
        end
        if (we2) begin
            smem2[addr2] <= wd2;
            pmem2[addr2] <= pw2;
        end
    end

    logic cur_busy, cur_done, cur_we;
    assign cur_busy = sel ? busy2 : busy1;
    assign cur_done = sel ? done2 : done1;
    assign cur_we   = sel ? we2 : we1;

    logic [1:0] ma [4];
    logic [1:0] mb [4];
    int exp_s [16];
    int exp_p [16];

    task automatic chk(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Reference: textbook NW recurrence over a bordered (n+1)x(n+1) table
    task automatic build_model(input int n, input int mis);
        int h [5][5];
        int d, u, l;
        h[0][0] = 0;
        for (int k = 1; k <= n; k++) begin
            h[0][k] = k * GAP;
            h[k][0] = k * GAP;
        end
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                d = h[r][c] + ((ma[r] == mb[c]) ? MATCH : mis);
                u = h[r][c+1] + GAP;
                l = h[r+1][c] + GAP;
                if (d >= u && d >= l) begin
                    h[r+1][c+1] = d; exp_p[r*n+c] = 0;
                end else if (u >= l) begin
                    h[r+1][c+1] = u; exp_p[r*n+c] = 1;
                end else begin
                    h[r+1][c+1] = l; exp_p[r*n+c] = 2;
                end
                exp_s[r*n+c] = h[r+1][c+1];
            end
        end
    endtask

    task automatic load_seqs(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                ma[k] = 2'($urandom_range(0, 3));
                mb[k] = 2'($urandom_range(0, 3));
            end
            if (sel) begin
                sa2[k] = ma[k]; sb2[k] = mb[k];
            end else begin
                sa1[k] = ma[k]; sb1[k] = mb[k];
            end
        end
    endtask

    task automatic run_fill(input string tag, input int n, input bit mid_start);
        int busy_cnt = 0, done_cnt = 0, done_cyc = -1, we_cnt = 0, we_pairs = 0;
        bit prev_we = 1'b0;
        int got;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 2*n*n + 4; c++) begin
            if (cur_busy) busy_cnt++;
            if (cur_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (cur_we) begin
                we_cnt++;
                if (prev_we) we_pairs++;
            end
            prev_we = cur_we;
            start = mid_start && (c == 1 || c == 4);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ":busy_cycles"}, busy_cnt, 2*n*n);
        chk({tag, ":done_pulses"}, done_cnt, 1);
        chk({tag, ":done_cycle"}, done_cyc, 2*n*n + 1);
        chk({tag, ":writes"}, we_cnt, n*n);
        chk({tag, ":back_to_back_we"}, we_pairs, 0);
        chk({tag, ":final_score"}, sel ? int'(fs2) : int'(fs1), exp_s[n*n-1]);
        for (int k = 0; k < n*n; k++) begin
            if (sel) got = int'(smem2[k]);
            else     got = int'(smem1[k]);
            chk($sformatf("%s:score[%0d]", tag, k), got, exp_s[k]);
            if (sel) got = int'(pmem2[k]);
            else     got = int'(pmem1[k]);
            chk($sformatf("%s:ptr[%0d]", tag, k), got, exp_p[k]);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ":busy"}, int'(busy1), 0);
        chk({tag, ":done"}, int'(done1), 0);
        chk({tag, ":en_read"}, int'(en1), 0);
        chk({tag, ":change_index"}, int'(ch1), 0);
        chk({tag, ":ram_we"}, int'(we1), 0);
        chk({tag, ":ram_addr"}, int'(addr1), 0);
        chk({tag, ":ram_wdata"}, int'(wd1), 0);
        chk({tag, ":ptr_wdata"}, int'(pw1), 0);
        chk({tag, ":final_score"}, int'(fs1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        ma = '{NT_A, NT_C, NT_G, NT_T}; mb = '{NT_A, NT_C, NT_G, NT_T};
        load_seqs(N1, 1'b0); build_model(N1, -1);
        run_fill("acgt", N1, 1'b0);
        chk("acgt:kat_final", int'(fs1), 4);
        chk("acgt:kat_diag_ptrs", int'(pmem1[0] | pmem1[5] | pmem1[10] | pmem1[15]), 0);

        ma = '{NT_A, NT_A, NT_A, NT_A}; mb = '{NT_C, NT_C, NT_C, NT_C};
        load_seqs(N1, 1'b0); build_model(N1, -1);
        run_fill("aaaa_cccc", N1, 1'b0);
        chk("aaaa_cccc:kat_final", int'(fs1), -4);
        chk("aaaa_cccc:kat_cell00", int'(smem1[0]), -1);

        load_seqs(N1, 1'b1); build_model(N1, -1);
        run_fill("mid_start", N1, 1'b1);

        // Reset during the CALC of cell (1,2), which is cycle 14
        load_seqs(N1, 1'b1); build_model(N1, -1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_reset:we", int'(we1), 1);
        chk("pre_reset:addr", int'(addr1), 6);
        rst = 1'b1;
        #1;
        chk_outputs_zero("mid_reset");
        @(negedge clk) rst = 1'b0;
        run_fill("after_reset", N1, 1'b0);

        load_seqs(N1, 1'b1); build_model(N1, -1);
        run_fill("b2b_first", N1, 1'b0);
        repeat (5) @(negedge clk);
        chk("b2b:final_hold", int'(fs1), exp_s[N1*N1-1]);
        run_fill("b2b_second", N1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            load_seqs(N1, 1'b1); build_model(N1, -1);
            run_fill($sformatf("random%0d", r), N1, 1'b0);
        end

        sel = 1'b1;
        ma[0] = NT_A; ma[1] = NT_C; mb[0] = NT_G; mb[1] = NT_T;
        load_seqs(N2, 1'b0); build_model(N2, -4);
        run_fill("tie", N2, 1'b0);
        chk("tie:kat_cell00_score", int'(smem2[0]), -4);
        chk("tie:kat_cell00_ptr", int'(pmem2[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nw_matrix_filler.md
# nw_matrix_filler

Control and datapath engine that fills the Needleman-Wunsch score matrix one cell per two clock cycles. It drives `en_read` and `change_index` of the row-major insertion counter and consumes its `i`, `j`, `end_filling`. For each cell it fetches the up-neighbour from the score RAM, computes the cell score and the traceback pointer, and writes both back. The block sits between the sequence ROMs and the score and pointer RAMs, and hands off to traceback when `done` pulses.

## Interface
- `N`, 128: sequence length; the matrix is N x N cells, with cell (i,j) aligning a[i] with b[j].
- `W`, 16: signed score width.
- `MATCH`, 1: signed W-bit match reward.
- `MISMATCH`, -1: signed W-bit mismatch penalty.
- `GAP`, -2: signed W-bit gap penalty.
- Derived: `IW` = clog2(N)+1 is the index width. `AW` = clog2(N*N) is the address width.

Ports:
- Reset `rst` is asynchronous and active-high. Clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `start`  in  1  begin a fill; sampled only in IDLE
- `i`, `j`  in  IW  current cell row and column from the insertion counter
- `end_filling`  in  1  counter flag, high when `en_read` is high and i=j=N-1
- `a_char`, `b_char`  in  2  nucleotide codes a[i] and b[j], combinational from the sequence ROMs
- `en_read`  out  1  counter enable
- `change_index`  out  1  one-cycle advance pulse to the counter
- `ram_addr`  out  AW  score and pointer RAM address
- `ram_we`  out  1  write strobe, shared by the score and pointer RAMs
- `ram_wdata`  out  W  cell score
- `ptr_wdata`  out  2  traceback pointer
- `ram_rdata`  in  W  score RAM read data, one-cycle synchronous latency
- `busy`  out  1  fill in progress
- `done`  out  1  one-cycle completion pulse
- `final_score`  out  W  score of cell (N-1,N-1), held until the next start

## Operation
- FSM states: IDLE, READ, CALC, DONE.
  - IDLE -> READ when `start` is high.
  - READ -> CALC unconditionally.
  - CALC -> READ when `end_filling` is low; CALC -> DONE when `end_filling` is high.
  - DONE -> IDLE unconditionally.
- READ:
  - `ram_addr` = (i-1)*N + j, the up cell. When i=0 the address value is don't-care and the read data is ignored.
  - `en_read`=1.
- CALC: the neighbour values are selected as follows.
  - up = `ram_rdata` if i>0, else (j+1)*GAP.
  - left = `left_q` if j>0, else (i+1)*GAP.
  - diag, when j>0, = `up_q`.
  - diag, when j=0 and i>0, = i*GAP.
  - diag, when j=0 and i=0, = 0.
- CALC: the three candidates are computed as follows.
  - s_d = diag + (a_char==b_char ? MATCH : MISMATCH).
  - s_u = up + GAP.
  - s_l = left + GAP.
- CALC: the score is the signed max of the three candidates. Ties resolve with priority diag > up > left.
- CALC: `ptr_wdata` is 00 for diag, 01 for up, 10 for left.
- CALC: `ram_addr` = i*N + j, `ram_we`=1, `change_index`=1, `en_read`=1.
- CALC register updates:
  - `left_q` <= score.
  - `up_q` <= up.
  - If `end_filling` is high, `final_score` <= score.
- The counter wraps to (0,0) after the last CALC, so the next fill needs no counter reset.
- Arithmetic is W-bit two's complement with no saturation. W must satisfy 2^(W-1) > 2*N*|GAP| + N*|MATCH|. Boundary products are truncated to W bits.
- `start` while not in IDLE is ignored.
- Reset mid-fill:
  - The FSM returns to IDLE and every output goes to 0.
  - Partial RAM contents are left as written.
  - The counter shares `rst`, so it also returns to (0,0).

## Timing
- Reset values: every output is 0; `left_q`, `up_q` and `final_score` are 0.
- Throughput is 2 cycles per cell.
- Counting from the edge that samples `start`:
  - The first READ occupies cycle 1.
  - The last CALC occupies cycle 2N².
  - `done`=1 during cycle 2N²+1.
- `busy`=1 in READ and CALC. It is 0 in IDLE and in DONE.
- `ram_we` and `change_index` are high only in CALC and never for two consecutive cycles.
- The counter must update i and j on the edge that closes CALC. i and j are stable throughout READ and CALC.
- The RAM must return data for the READ address in the following CALC cycle. No write-to-read forwarding is needed, because the up cell was written at least 2N-2 cycles earlier.

## Structure
- Shared package `nw_pkg` holds:
  - the pointer codes `PTR_DIAG`=2'b00, `PTR_UP`=2'b01, `PTR_LEFT`=2'b10;
  - the state encoding;
  - the nucleotide codes;
  - the default score constants.
- One combinational sub-module, `nw_max3`. It takes three signed W-bit scores and returns the maximum and its 2-bit pointer with diag>up>left priority.
- The bench instantiates this block with the insertion counter and behavioural score and pointer RAMs.

## Test plan
- N=4, a=ACGT, b=ACGT, defaults -> after `done`: `final_score`=4, all diagonal pointers=00, `done` in cycle 33 after `start`.
- N=4, a=AAAA, b=CCCC -> `final_score`=-4. Cell (0,0): score -1 with ptr 00, since s_d=-1 beats s_u=s_l=-4.
- Tie check, N=2, MISMATCH=-4, GAP=-2, a=AC, b=GT -> cell (0,0) candidates are all -4; the write is score -4, ptr 00.
- `start` pulsed in READ and again in CALC mid-fill -> ignored; exactly 2N² cycles of `busy` and a single `done` pulse.
- Reset asserted during the CALC of cell (1,2) -> outputs 0 immediately, state IDLE. A fresh `start` refills from (0,0) and reproduces the golden matrix.
- Back-to-back fills with no reset -> the second fill starts at (0,0) and gives an identical `final_score`. `final_score` holds between fills.
